// File: rtl/mult_div_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// The core drives start/op/a/b; the unit returns busy/stall/done and the HI/LO registers.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Results are computed at issue and held back until the fixed latency has elapsed.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  mult_div_if.slave   bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               wr_q, wr_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Products are taken on 2*WIDTH-bit extended operands; the low 2*WIDTH bits are exact.
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  assign prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // One unsigned divider serves both flavours: signed division works on magnitudes
  // and fixes signs afterwards, which also yields the MIN/-1 result with no special case.
  logic             div_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] num, den, den_safe;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] quot, rem;

  assign div_signed = (bus.op == OP_DIV);
  assign a_neg      = div_signed & bus.a[WIDTH-1];
  assign b_neg      = div_signed & bus.b[WIDTH-1];
  assign num        = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign den        = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign den_safe   = (bus.b == '0) ? WIDTH'(1) : den;
  assign q_mag      = num / den_safe;
  assign r_mag      = num % den_safe;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              res_hi_d = prod_s[2*WIDTH-1:WIDTH];
              res_lo_d = prod_s[WIDTH-1:0];
              wr_d     = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = RUN;
            end
            OP_MULTU: begin
              res_hi_d = prod_u[2*WIDTH-1:WIDTH];
              res_lo_d = prod_u[WIDTH-1:0];
              wr_d     = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quot;
              // Divide by zero still runs the full latency but leaves HI/LO alone.
              wr_d     = (bus.b != '0);
              cnt_d    = DIV_LOAD;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.stall = (state_q == RUN) |
                     (bus.start & (bus.op >= OP_MULT) & (bus.op <= OP_DIVU));
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, MTHI/MTLO, busy lockout and reset abort.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issues one op at the current (post-edge) time and runs until busy drops.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output logic done_early, output logic done_end);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    busy_cycles = 0;
    done_early  = 1'b0;
    while (bus.busy && busy_cycles < 200) begin
      busy_cycles++;
      if (bus.done) done_early = 1'b1;
      @(posedge clk); #1;
    end
    done_end = bus.done;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done=%0b",
             op, a, b, bus.hi, bus.lo, busy_cycles, done_end);
  endtask

  task automatic test_reset;
    rst_ni    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_mult;
    int n; logic de, dn;
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, n, de, dn);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL mult_done_early: got %b expected 0", de); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", dn); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", bus.lo); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_fall: got %b expected 0", bus.done); end
  endtask

  task automatic test_multu;
    int n; logic de, dn;
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, n, de, dn);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", bus.lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int n; logic de, dn;
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n, de, dn);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_len: got %0d expected 10", n); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", dn); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
    @(posedge clk); #1;
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, n, de, dn);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_divisor_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL div_neg_divisor_hi: got %h expected 00000001", bus.hi); end
    @(posedge clk); #1;
    run_op(3'd4, 32'd7, 32'd2, n, de, dn);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_len: got %0d expected 10", n); end
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 00000003", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", bus.hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_divzero;
    int n; logic de, dn;
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000_1234;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'd0;
    $display("op=5 a=00001234 -> hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi: got %h expected 00001234", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", bus.done); end
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h0000_0055;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rsvd_stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'd0;
    $display("op=7 a=00000055 -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL rsvd_lo: got %h expected 00000003", bus.lo); end
    run_op(3'd3, 32'd9, 32'd0, n, de, dn);
    checks++; if (n != 10) begin errors++; $display("FAIL divzero_busy_len: got %0d expected 10", n); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL divzero_done: got %b expected 1", dn); end
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL divzero_hi: got %h expected 00001234", bus.hi); end
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divzero_lo: got %h expected 00000003", bus.lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_lockout;
    int  n;
    logic stall_ok;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL start_cycle_stall: got %b expected 1", bus.stall); end
    @(posedge clk); #1;
    // Hold an MTLO request and scramble operands for the whole busy window.
    bus.op = 3'd6; bus.a = 32'h0000_00AA; bus.b = 32'd3;
    n = 0;
    stall_ok = 1'b1;
    while (bus.busy && n < 200) begin
      n++;
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.op = 3'd0;
    $display("op=3 a=00000064 b=00000007 with MTLO held -> hi=%h lo=%h busy_cycles=%0d", bus.hi, bus.lo, n);
    checks++; if (n != 10) begin errors++; $display("FAIL lockout_busy_len: got %0d expected 10", n); end
    checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL lockout_stall: got %b expected 1", stall_ok); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL lockout_done: got %b expected 1", bus.done); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL lockout_lo: got %h expected 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL lockout_hi: got %h expected 00000002", bus.hi); end
    @(posedge clk); #1;
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL lockout_lo_hold: got %h expected 0000000e", bus.lo); end
  endtask

  task automatic test_back_to_back;
    int n; logic de, dn;
    run_op(3'd2, 32'd6, 32'd7, n, de, dn);
    // Next op issued in the done cycle of the previous one.
    run_op(3'd2, 32'd3, 32'd5, n, de, dn);
    checks++; if (n != 5) begin errors++; $display("FAIL b2b_busy_len: got %0d expected 5", n); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL b2b_done_early: got %b expected 0", de); end
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL b2b_lo: got %h expected 0000000f", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_hi: got %h expected 00000000", bus.hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int n; logic de, dn;
    logic seen;
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd11; bus.b = 32'd13;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'd0;
    repeat (2) begin @(posedge clk); #1; end
    rst_ni = 1'b0;
    #1;
    $display("reset during MULT -> hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h expected 00000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h expected 00000000", bus.hi); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done || bus.lo != 32'd0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, de, dn);
    checks++; if (n != 10) begin errors++; $display("FAIL ovf_busy_len: got %0d expected 10", n); end
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h expected 00000000", bus.hi); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_divzero();
    test_busy_lockout();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
